// File: rtl/gcd_control_unit.sv
// Sequencer for the register-file/ALU datapath: computes gcd(R1, R2) by repeated subtraction.
// Moore control outputs are decoded from the next state and registered alongside it.
module gcd_control_unit #(
  parameter logic [15:0] MAX_ITER = 16'd1000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Start,
  input  logic [15:0] Datapath,
  output logic        IE,
  output logic [3:0]  WA,
  output logic        WE,
  output logic [3:0]  RAA,
  output logic        REA,
  output logic [3:0]  RAB,
  output logic        REB,
  output logic [3:0]  S_ALU1,
  output logic        Cin,
  output logic        OE,
  output logic        Done,
  output logic        Busy,
  output logic        Error,
  output logic [15:0] Iter
);

  typedef enum logic [3:0] {
    StIdle, StLoadA, StLoadB, StChkA, StChkB, StCmp,
    StSubAb, StSubBa, StOutA, StOutB, StDone
  } state_e;

  localparam logic [3:0] AluPassA = 4'h0;
  localparam logic [3:0] AluSub   = 4'h2;

  state_e      state_q, state_d;
  logic [15:0] iter_q, iter_d;
  logic        error_q, error_d;

  logic        ie_q, ie_d;
  logic [3:0]  wa_q, wa_d;
  logic        we_q, we_d;
  logic [3:0]  raa_q, raa_d;
  logic        rea_q, rea_d;
  logic [3:0]  rab_q, rab_d;
  logic        reb_q, reb_d;
  logic [3:0]  s_alu1_q, s_alu1_d;
  logic        cin_q, cin_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic dp_zero;
  assign dp_zero = (Datapath == 16'h0000);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StLoadA;
          iter_d  = 16'h0000;
          error_d = 1'b0;
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StChkA;
      StChkA:  state_d = dp_zero ? StOutB : StChkB;
      StChkB:  state_d = dp_zero ? StOutA : StCmp;
      StCmp: begin
        if (dp_zero) begin
          state_d = StOutA;
        end else if (iter_q == MAX_ITER) begin
          // Abort instead of entering another subtract step; Out keeps its old value.
          state_d = StDone;
          error_d = 1'b1;
        end else if (Datapath[15]) begin
          state_d = StSubBa;
        end else begin
          state_d = StSubAb;
        end
      end
      StSubAb, StSubBa: begin
        if (iter_q != 16'hFFFF) iter_d = iter_q + 16'd1;
        state_d = StCmp;
      end
      StOutA, StOutB: state_d = StDone;
      StDone:  if (!Start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ie_d     = 1'b0;
    wa_d     = 4'd0;
    we_d     = 1'b0;
    raa_d    = 4'd0;
    rea_d    = 1'b0;
    rab_d    = 4'd0;
    reb_d    = 1'b0;
    s_alu1_d = AluPassA;
    cin_d    = 1'b0;
    oe_d     = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b1;
    unique case (state_d)
      StIdle: busy_d = 1'b0;
      StLoadA: begin
        ie_d = 1'b1;
        we_d = 1'b1;
        wa_d = 4'd1;
      end
      StLoadB: begin
        ie_d = 1'b1;
        we_d = 1'b1;
        wa_d = 4'd2;
      end
      StChkA: begin
        rea_d = 1'b1;
        raa_d = 4'd1;
      end
      StChkB: begin
        rea_d = 1'b1;
        raa_d = 4'd2;
      end
      StCmp, StSubAb: begin
        rea_d    = 1'b1;
        reb_d    = 1'b1;
        raa_d    = 4'd1;
        rab_d    = 4'd2;
        s_alu1_d = AluSub;
        cin_d    = 1'b1;
        if (state_d == StSubAb) begin
          we_d = 1'b1;
          wa_d = 4'd1;
        end
      end
      StSubBa: begin
        rea_d    = 1'b1;
        reb_d    = 1'b1;
        raa_d    = 4'd2;
        rab_d    = 4'd1;
        s_alu1_d = AluSub;
        cin_d    = 1'b1;
        we_d     = 1'b1;
        wa_d     = 4'd2;
      end
      StOutA, StOutB: begin
        rea_d = 1'b1;
        raa_d = (state_d == StOutA) ? 4'd1 : 4'd2;
        oe_d  = 1'b1;
      end
      StDone: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= StIdle;
      iter_q   <= 16'h0000;
      error_q  <= 1'b0;
      ie_q     <= 1'b0;
      wa_q     <= 4'd0;
      we_q     <= 1'b0;
      raa_q    <= 4'd0;
      rea_q    <= 1'b0;
      rab_q    <= 4'd0;
      reb_q    <= 1'b0;
      s_alu1_q <= 4'd0;
      cin_q    <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      error_q  <= error_d;
      ie_q     <= ie_d;
      wa_q     <= wa_d;
      we_q     <= we_d;
      raa_q    <= raa_d;
      rea_q    <= rea_d;
      rab_q    <= rab_d;
      reb_q    <= reb_d;
      s_alu1_q <= s_alu1_d;
      cin_q    <= cin_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign IE     = ie_q;
  assign WA     = wa_q;
  assign WE     = we_q;
  assign RAA    = raa_q;
  assign REA    = rea_q;
  assign RAB    = rab_q;
  assign REB    = reb_q;
  assign S_ALU1 = s_alu1_q;
  assign Cin    = cin_q;
  assign OE     = oe_q;
  assign Done   = done_q;
  assign Busy   = busy_q;
  assign Error  = error_q;
  assign Iter   = iter_q;

endmodule

// File: tb/tb_gcd_control_unit.sv
// Bench for gcd_control_unit: behavioural register-file/ALU datapath plus a scoreboard of
// expected gcd results built from a reference subtraction model.
module tb_gcd_control_unit;

  localparam logic [15:0] MaxIter = 16'd10;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [15:0] alu;
  logic        ie, we, rea, reb, cin, oe, done, busy, error;
  logic [3:0]  wa, raa, rab, s_alu1;
  logic [15:0] iter;

  logic [15:0] op_a, op_b, data_in;
  logic [15:0] rf [16];
  logic [15:0] out_q;
  logic [15:0] a_bus, b_bus;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [15:0] out;
    logic [15:0] iter;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_out;

  gcd_control_unit #(.MAX_ITER(MaxIter)) dut (
    .CLK     (clk),
    .nRST    (n_rst),
    .Start   (start),
    .Datapath(alu),
    .IE      (ie),
    .WA      (wa),
    .WE      (we),
    .RAA     (raa),
    .REA     (rea),
    .RAB     (rab),
    .REB     (reb),
    .S_ALU1  (s_alu1),
    .Cin     (cin),
    .OE      (oe),
    .Done    (done),
    .Busy    (busy),
    .Error   (error),
    .Iter    (iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: combinational reads and ALU, writes and output register on the edge.
  assign data_in = (wa == 4'd1) ? op_a : op_b;
  assign a_bus   = rea ? rf[raa] : 16'h0000;
  assign b_bus   = reb ? rf[rab] : 16'h0000;
  always_comb begin
    alu = 16'h0000;
    if (s_alu1 == 4'h0) alu = a_bus;
    else if (s_alu1 == 4'h2) alu = a_bus + ~b_bus + {15'd0, cin};
  end

  always @(posedge clk) begin
    if (we) rf[wa] <= ie ? data_in : alu;
    if (oe) out_q <= alu;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input int a, input int b, input logic [15:0] prev_out);
    exp_t e;
    int   x, y, k;
    bit   fin;
    x = a; y = b; k = 0; fin = 0;
    e.err = 1'b0;
    e.out = 16'h0;
    e.iter = 16'h0;
    e.lat = 0;
    if (x == 0) begin
      e.out = 16'(y);
      e.lat = 5;
    end else if (y == 0) begin
      e.out = 16'(x);
      e.lat = 6;
    end else begin
      for (int s = 0; s < 100000 && !fin; s++) begin
        if (x == y) begin
          e.out = 16'(x);
          e.iter = 16'(k);
          e.lat = 7 + 2 * k;
          fin = 1;
        end else if (k == int'(MaxIter)) begin
          e.err = 1'b1;
          e.out = prev_out;
          e.iter = 16'(k);
          e.lat = 6 + 2 * k;
          fin = 1;
        end else begin
          if (x < y) y = y - x;
          else x = x - y;
          k++;
        end
      end
    end
    return e;
  endfunction

  task automatic start_run(input int a, input int b);
    exp_t e;
    e = ref_model(a, b, last_out);
    if (!e.err) last_out = e.out;
    sb.push_back(e);
    op_a  = 16'(a);
    op_b  = 16'(b);
    start = 1'b1;
  endtask

  task automatic wait_done();
    exp_t e;
    int   cyc;
    int   oes;
    bit   got;
    cyc = 0; oes = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (i == 0) check_val("load_a", 32'({ie, we, wa, busy}), 32'({1'b1, 1'b1, 4'd1, 1'b1}));
      if (oe) oes++;
      if (done) got = 1;
    end
    check_val("done_seen", 32'(done), 32'd1);
    e = sb.pop_front();
    check_val("lat", 32'(cyc), 32'(e.lat));
    check_val("iter", 32'(iter), 32'(e.iter));
    check_val("error", 32'(error), 32'(e.err));
    check_val("oe_pulses", 32'(oes), e.err ? 32'd0 : 32'd1);
    check_val("out", 32'(out_q), 32'(e.out));
    check_val("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic release_start();
    start = 1'b0;
    @(negedge clk);
    check_val("back_idle", 32'({done, busy}), 32'd0);
  endtask

  task automatic do_run(input int a, input int b);
    @(negedge clk);
    start_run(a, b);
    wait_done();
    release_start();
  endtask

  initial begin
    bit hit;
    n_cmp = 0;
    n_bad = 0;
    last_out = 16'h0;
    out_q = 16'h0;
    n_rst = 1'b0;
    start = 1'b0;
    op_a = 16'h0;
    op_b = 16'h0;
    repeat (3) @(negedge clk);
    check_val("reset_outs",
              32'({ie, wa, we, raa, rea, rab, reb, s_alu1, cin, oe, done, busy, error}), 32'd0);
    check_val("reset_iter", 32'(iter), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    do_run(12, 18);
    do_run(0, 7);
    do_run(9, 0);
    do_run(5, 5);
    do_run(1, 32767);
    do_run(1, 11);
    do_run(0, 0);

    // Reset in the middle of a subtract loop, then a fresh run.
    @(negedge clk);
    op_a = 16'd12;
    op_b = 16'd18;
    start = 1'b1;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (we && !ie && wa == 4'd2 && s_alu1 == 4'h2) hit = 1;
    end
    check_val("saw_sub_ba", 32'(hit), 32'd1);
    n_rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_val("mid_reset_outs",
              32'({ie, wa, we, raa, rea, rab, reb, s_alu1, cin, oe, done, busy, error}), 32'd0);
    check_val("mid_reset_iter", 32'(iter), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    do_run(21, 14);

    // Start held high through DONE must not restart.
    @(negedge clk);
    start_run(27, 36);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_done", 32'({done, ie, busy}), 32'({1'b1, 1'b0, 1'b0}));
    end
    release_start();
    do_run(8, 12);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
